// File: rtl/instr_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : instr_deserializer
// Purpose  : Assembles a byte-serial program stream into an instruction word
//            plus an opcode-selected immediate, and hands both to decode over
//            a valid/ready handshake. Flags halt/illegal opcodes, parks in a
//            halted state after a halt instruction, supports a sync flush.
// Revision : 1.0 - initial release
// ============================================================================
module instr_deserializer #(
  parameter int                        DATA_W           = 8,
  parameter int                        INSTR_W          = 16,
  parameter int                        IMM_W            = 16,
  parameter int                        OPC_W            = 3,
  parameter logic [(1<<OPC_W)-1:0]     IMM_OPC_MASK     = 8'h12,
  parameter logic [(1<<OPC_W)-1:0]     ILLEGAL_OPC_MASK = 8'h60,
  parameter logic [OPC_W-1:0]          HALT_OPC         = 3'd7
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active-low
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [IMM_W-1:0]   imm,
  output logic               has_imm,
  output logic               halt,
  output logic               error
);

  // Beat counts; INSTR_W and IMM_W are expected to be multiples of DATA_W.
  localparam int IB      = INSTR_W / DATA_W;
  localparam int MB      = IMM_W / DATA_W;
  localparam int CNT_MAX = (IB > MB) ? IB : MB;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_IMM     = 2'd1,
    S_HOLD    = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [INSTR_W-1:0] r_instr;
  logic [IMM_W-1:0]   r_imm;
  logic               r_out_valid;
  logic               r_has_imm;
  logic               r_halt;
  logic               r_error;

  logic [INSTR_W-1:0] w_instr_next;
  logic [IMM_W-1:0]   w_imm_next;
  logic [OPC_W-1:0]   w_opc;
  logic               w_accept;
  logic               w_last_instr;
  logic               w_last_imm;
  logic               w_opc_illegal;
  logic               w_opc_imm;

  // Upstream may push only while a word is being gathered.
  assign in_ready     = (r_state == S_COLLECT) || (r_state == S_IMM);
  assign w_accept     = in_valid && in_ready;
  assign w_last_instr = (r_count == CNT_W'(IB - 1));
  assign w_last_imm   = (r_count == CNT_W'(MB - 1));

  // Instruction word with the current beat merged in at the beat slot (LSB first).
  always_comb begin
    w_instr_next = r_instr;
    for (int b = 0; b < IB; b++) begin
      if (r_count == CNT_W'(b)) w_instr_next[b*DATA_W +: DATA_W] = in_data;
    end
  end

  // Immediate word with the current beat merged in at the beat slot (LSB first).
  always_comb begin
    w_imm_next = r_imm;
    for (int b = 0; b < MB; b++) begin
      if (r_count == CNT_W'(b)) w_imm_next[b*DATA_W +: DATA_W] = in_data;
    end
  end

  // Opcode decode on the word as it will look after the final beat lands;
  // an illegal opcode never pulls in an immediate.
  assign w_opc         = w_instr_next[OPC_W-1:0];
  assign w_opc_illegal = ILLEGAL_OPC_MASK[w_opc];
  assign w_opc_imm     = IMM_OPC_MASK[w_opc] && !w_opc_illegal;

  // Main sequencer: collect instruction, optional immediate, hold for decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_COLLECT;
      r_count     <= '0;
      r_instr     <= '0;
      r_imm       <= '0;
      r_out_valid <= 1'b0;
      r_has_imm   <= 1'b0;
      r_halt      <= 1'b0;
      r_error     <= 1'b0;
    end else if (flush) begin
      r_state     <= S_COLLECT;
      r_count     <= '0;
      r_instr     <= '0;
      r_imm       <= '0;
      r_out_valid <= 1'b0;
      r_has_imm   <= 1'b0;
      r_halt      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            r_instr <= w_instr_next;
            if (w_last_instr) begin
              r_count   <= '0;
              r_imm     <= '0;
              r_has_imm <= w_opc_imm;
              r_halt    <= (w_opc == HALT_OPC);
              r_error   <= w_opc_illegal;
              if (w_opc_imm) begin
                r_state <= S_IMM;
              end else begin
                r_state     <= S_HOLD;
                r_out_valid <= 1'b1;
              end
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
        end
        S_IMM: begin
          if (w_accept) begin
            r_imm <= w_imm_next;
            if (w_last_imm) begin
              r_count     <= '0;
              r_state     <= S_HOLD;
              r_out_valid <= 1'b1;
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= r_halt ? S_HALTED : S_COLLECT;
          end
        end
        default: begin
          // Halted: only flush or reset leaves this state.
          r_state <= S_HALTED;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign instr     = r_instr;
  assign imm       = r_imm;
  assign has_imm   = r_has_imm;
  assign halt      = r_halt;
  assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_instr_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_deserializer
// Purpose  : Directed self-checking bench for instr_deserializer (default
//            16/16 configuration) plus a 24/8 configuration against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] instr;
  logic [15:0] imm;
  logic        has_imm, halt, error;

  logic        s_flush;
  logic        s_in_valid;
  logic [7:0]  s_in_data;
  logic        s_in_ready;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [23:0] s_instr;
  logic [7:0]  s_imm;
  logic        s_has_imm, s_halt, s_error;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_deserializer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .imm(imm), .has_imm(has_imm), .halt(halt), .error(error)
  );

  instr_deserializer #(.DATA_W(8), .INSTR_W(24), .IMM_W(8)) dut_w24 (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .instr(s_instr), .imm(s_imm), .has_imm(s_has_imm), .halt(s_halt), .error(s_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one beat to the default instance; it must be accepted on this edge.
  task automatic beat(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    check("beat_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic s_beat(input logic [7:0] d);
    s_in_valid = 1'b1;
    s_in_data  = d;
    check("w24_in_ready", {31'd0, s_in_ready}, 32'd1);
    tick();
    s_in_valid = 1'b0;
  endtask

  // Check the full payload of the default instance: instr, imm, {has_imm,halt,error}.
  task automatic payload(input string tag, input logic [15:0] ei, input logic [15:0] em,
                         input logic [2:0] ef);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_instr"}, {16'd0, instr}, {16'd0, ei});
    check({tag, "_imm"},   {16'd0, imm},   {16'd0, em});
    check({tag, "_flags"}, {29'd0, has_imm, halt, error}, {29'd0, ef});
  endtask

  // One-cycle handshake on the default instance; afterwards out_valid must be low.
  task automatic consume(input string tag, input logic exp_ready);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
  endtask

  initial begin
    logic [23:0] ri;
    logic [7:0]  rm;
    logic [2:0]  op;
    logic        e_imm, e_halt, e_err, r, done;
    int          n;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_instr",     {16'd0, instr},     32'd0);
    check("rst_imm",       {16'd0, imm},       32'd0);
    check("rst_flags",     {29'd0, has_imm, halt, error}, 32'd0);
    #11 rst = 1'b1;
    tick();

    // Plain instruction, opcode 0.
    beat(8'h08);
    check("plain_mid_ov", {31'd0, out_valid}, 32'd0);
    beat(8'h12);
    payload("plain", 16'h1208, 16'h0000, 3'b000);
    check("plain_hold_in_ready", {31'd0, in_ready}, 32'd0);
    consume("plain", 1'b1);

    // Immediate instruction, opcode 1, with 5 cycles of backpressure.
    beat(8'h01); beat(8'hA0); beat(8'h34);
    check("imm_mid_ov", {31'd0, out_valid}, 32'd0);
    beat(8'h12);
    payload("imm", 16'hA001, 16'h1234, 3'b100);
    for (int i = 0; i < 5; i++) begin
      tick();
      payload("imm_stall", 16'hA001, 16'h1234, 3'b100);
      check("imm_stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    consume("imm", 1'b1);

    // Gappy stream, opcode 4, three idle cycles between beats.
    beat(8'h04);
    for (int i = 0; i < 3; i++) begin tick(); check("gap_ov", {31'd0, out_valid}, 32'd0); end
    beat(8'h00);
    for (int i = 0; i < 3; i++) begin tick(); check("gap_ov", {31'd0, out_valid}, 32'd0); end
    beat(8'hCD);
    for (int i = 0; i < 3; i++) begin tick(); check("gap_ov", {31'd0, out_valid}, 32'd0); end
    beat(8'hAB);
    payload("gap", 16'h0004, 16'hABCD, 3'b100);
    consume("gap", 1'b1);

    // Illegal opcode 5.
    beat(8'h05); beat(8'h00);
    payload("illegal", 16'h0005, 16'h0000, 3'b001);
    consume("illegal", 1'b1);

    // Halt opcode 7, then parked until flush.
    beat(8'h07); beat(8'h00);
    payload("halt", 16'h0007, 16'h0000, 3'b010);
    consume("halt", 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halted_in_ready", {31'd0, in_ready}, 32'd0);
      check("halted_ov", {31'd0, out_valid}, 32'd0);
    end
    flush = 1'b1; tick(); flush = 1'b0;
    check("unhalt_in_ready", {31'd0, in_ready}, 32'd1);
    check("unhalt_flags", {29'd0, has_imm, halt, error}, 32'd0);
    check("unhalt_instr", {16'd0, instr}, 32'd0);

    // Flush with a beat offered on the same edge: beat dropped.
    beat(8'h01); beat(8'hA0); beat(8'h34);
    in_valid = 1'b1; in_data = 8'h12; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_ov", {31'd0, out_valid}, 32'd0);
    check("flush_instr", {16'd0, instr}, 32'd0);
    check("flush_imm", {16'd0, imm}, 32'd0);
    beat(8'h08); beat(8'h12);
    payload("post_flush", 16'h1208, 16'h0000, 3'b000);
    consume("post_flush", 1'b1);

    // Async reset mid-cycle discards the partial instruction immediately.
    beat(8'h01); beat(8'hA0); beat(8'h34);
    check("pre_rst_instr", {16'd0, instr}, 32'h0000A001);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("async_rst_instr", {16'd0, instr}, 32'd0);
    check("async_rst_imm", {16'd0, imm}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b1;
    tick();
    beat(8'h08); beat(8'h12);
    payload("post_rst", 16'h1208, 16'h0000, 3'b000);
    consume("post_rst", 1'b1);

    // 24-bit instruction / 8-bit immediate instance against a reference model.
    for (int k = 0; k < 1000; k++) begin
      ri     = 24'($urandom);
      rm     = 8'($urandom);
      op     = ri[2:0];
      e_err  = (op == 3'd5) || (op == 3'd6);
      e_imm  = (op == 3'd1) || (op == 3'd4);
      e_halt = (op == 3'd7);
      s_beat(ri[7:0]); s_beat(ri[15:8]); s_beat(ri[23:16]);
      if (e_imm) s_beat(rm);
      n = 0;
      while (!s_out_valid && n < 10) begin tick(); n++; end
      check("w24_valid", {31'd0, s_out_valid}, 32'd1);
      check("w24_instr", {8'd0, s_instr}, {8'd0, ri});
      check("w24_imm", {24'd0, s_imm}, e_imm ? {24'd0, rm} : 32'd0);
      check("w24_flags", {29'd0, s_has_imm, s_halt, s_error}, {29'd0, e_imm, e_halt, e_err});
      done = 1'b0; n = 0;
      while (!done && n < 100) begin
        r = 1'($urandom_range(0, 1));
        s_out_ready = r;
        tick();
        if (r) done = 1'b1;
        n++;
      end
      s_out_ready = 1'b0;
      check("w24_xfer", {31'd0, s_out_valid}, 32'd0);
      if (e_halt) begin
        check("w24_halted", {31'd0, s_in_ready}, 32'd0);
        s_flush = 1'b1; tick(); s_flush = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_deserializer.md
Name: instr_deserializer

Overview:
- Parametrised byte-serial instruction assembler.
- Sits between the program-memory byte stream and decode.
- Collects a fixed-width instruction word, then an optional immediate selected by opcode, and presents both to decode.
- Uses valid/ready handshakes on both sides, with backpressure, opcode error/halt flags, a halted state and a synchronous flush.

Parameters:
- DATA_W, 8: serial beat width in bits.
- INSTR_W, 16: instruction width; must be a multiple of DATA_W.
- IMM_W, 16: immediate width; must be a multiple of DATA_W.
- OPC_W, 3: opcode field width, located at instr[OPC_W-1:0].
- IMM_OPC_MASK, 8'h12: bit k set means opcode k carries an immediate (default: opcodes 1 and 4).
- ILLEGAL_OPC_MASK, 8'h60: bit k set means opcode k is illegal (default: opcodes 5 and 6).
- HALT_OPC, 3'd7: halt opcode.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: reset, asynchronous and active-low.
- flush, input, 1: synchronous abort; clears all state.
- in_valid, input, 1: upstream beat valid.
- in_data, input, DATA_W: upstream beat.
- in_ready, output, 1: block accepts a beat this cycle.
- out_valid, output, 1: assembled instruction available.
- out_ready, input, 1: decode consumes the instruction.
- instr, output, INSTR_W: assembled instruction word.
- imm, output, IMM_W: assembled immediate; 0 when the opcode carries none.
- has_imm, output, 1: the opcode carries an immediate.
- halt, output, 1: payload flag; opcode == HALT_OPC.
- error, output, 1: payload flag; opcode is illegal per ILLEGAL_OPC_MASK.

Behaviour:
- Derived constants: IB = INSTR_W/DATA_W beats; MB = IMM_W/DATA_W beats. Beat counter width is clog2 of max(IB, MB)+1.
- States:
  - COLLECT: gathering instruction beats.
  - IMM: gathering immediate beats.
  - HOLD: presenting the assembled instruction.
  - HALTED: stopped after a halt instruction.
- Reset (rst low, async): state=COLLECT, count=0, instr=0, imm=0; out_valid, has_imm, halt and error all 0.
- in_ready = (state==COLLECT) | (state==IMM). It is combinational from state and so is 1 while in reset; upstream must hold in_valid low during reset.
- Accept = in_valid & in_ready.
- COLLECT:
  - Accept writes in_data to instr[count*DATA_W +: DATA_W] (first beat is the least-significant byte), then count++.
  - On accept with count==IB-1: count←0. Opcode = instr[OPC_W-1:0] after the write; if IB==1 this is in_data[OPC_W-1:0].
  - If IMM_OPC_MASK[opcode]=1, go to IMM; otherwise go to HOLD with imm=0.
- IMM:
  - Accept writes imm[count*DATA_W +: DATA_W], count++.
  - Accept with count==MB-1: count←0, go to HOLD.
- HOLD:
  - out_valid=1. instr, imm, has_imm, halt and error are registered and stable until transfer.
  - Transfer = out_valid & out_ready. On transfer, go to HALTED if halt=1, else to COLLECT.
  - out_valid drops the cycle after transfer. There is no overlap of input and output: one bubble per instruction.
- Latency: out_valid rises the cycle after the final beat (instruction or immediate) is accepted.
- HALTED: in_ready=0, out_valid=0; stays until flush or reset.
- Illegal opcode: presented normally with error=1. Never loads the immediate even if both masks are set (illegal overrides IMM_OPC_MASK). Decode decides the handling.
- flush high: next state COLLECT, count=0, instr=imm=0, all flags 0. Flush has priority over accept and transfer in the same cycle; a beat offered that cycle is dropped.
- Gaps (in_valid low mid-instruction): state and count hold indefinitely; there is no timeout.
- out_ready ignored outside HOLD.
- Async reset mid-instruction discards partial data immediately.
- Immediate assembly is independent of instr; the instr fields do not change in IMM.

Test Plan:
- Plain instruction: beats 0x08, 0x12 (opcode 0) → HOLD one cycle after the 2nd accept, instr=0x1208, imm=0, has_imm=0, halt=0, error=0.
- Immediate: beats 0x01, 0xA0, 0x34, 0x12 (opcode 1) → instr=0xA001, imm=0x1234, has_imm=1. out_ready held low 5 cycles: outputs stable and in_ready=0 throughout; transfer on the 6th cycle, then in_ready=1 next cycle.
- Gappy stream: immediate opcode 4 with in_valid low 3 cycles between every beat → same result as gap-free; the count is not corrupted.
- Illegal and halt:
  - Beats 0x05, 0x00 → error=1, has_imm=0; after transfer, accepts again.
  - Beats 0x07, 0x00 → halt=1; after transfer, in_ready=0 for 10 cycles.
  - flush → in_ready=1 the next cycle.
- Flush and reset mid-operation:
  - After 3 of 4 beats of an immediate instruction, pulse flush together with in_valid → that beat is dropped, state COLLECT, instr=0.
  - Repeat with an async rst assertion mid-clock-cycle → outputs cleared without waiting for a clock edge.
- Parameter sweep: DATA_W=8, INSTR_W=24, IMM_W=8 → 3 instruction beats (LSB first) plus 1 immediate beat. Check field placement against a reference model over 1000 random instructions with random out_ready.
